booth_multiplier_seq: RTL

Iterative radix-2 Booth multiplier with a parameterised operand width and a per-operation signed/unsigned mode. It retires one Booth step per clock and exposes valid/ready handshakes on both the operand and product sides. It is the sequential, width-generic successor to the team's combinational 4-bit Booth multiplier. It sits in arithmetic datapaths where area matters more than throughput.

---
 rtl/booth_multiplier_seq_if.sv | 31 +++
 rtl/booth_multiplier_seq.sv | 122 ++++++++++++
 2 files changed

// File: rtl/booth_multiplier_seq_if.sv
// booth_multiplier_seq_if
// Handshake and data bundle for the sequential Booth multiplier.
//   in_valid / in_ready   : operand handshake (a, b, signed_op travel with it)
//   out_valid / out_ready : product handshake (product travels with it)
//   busy                  : multiplier holds an operation (BUSY or DONE)
// Modports:
//   master : producer/consumer side that drives operands and accepts products
//   slave  : the multiplier itself
interface booth_multiplier_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_op;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, a, b, signed_op, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, signed_op, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq
// Iterative radix-2 Booth multiplier, one Booth step per clock.
// Operands are widened to N = WIDTH+1 bits (sign- or zero-extended by
// signed_op) so a single signed datapath covers both modes.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, highest priority
//   bus  : booth_multiplier_seq_if.slave (operand and product handshakes)
module booth_multiplier_seq #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    booth_multiplier_seq_if.slave bus
);
    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(N + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N:0]      acc_q, acc_d;      // A: one bit wider so -M of the most negative M fits
    logic [N-1:0]    mq_q, mq_d;        // Q: multiplier, shifted out LSB first
    logic [N-1:0]    mcand_q, mcand_d;  // M: multiplicand
    logic            q1_q, q1_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   product_q, product_d;

    logic [N:0]      m_sext_s;
    logic [N:0]      sum_s;
    logic [2*N:0]    step_s;            // {A,Q} after add/sub and arithmetic shift

    // Booth add/subtract followed by the arithmetic right shift of {A,Q}
    always_comb begin
        m_sext_s = {mcand_q[N-1], mcand_q};
        case ({mq_q[0], q1_q})
            2'b10:   sum_s = acc_q - m_sext_s;
            2'b01:   sum_s = acc_q + m_sext_s;
            default: sum_s = acc_q;
        endcase
        step_s = {sum_s[N], sum_s, mq_q[N-1:1]};
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        mcand_d   = mcand_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    mq_d    = {bus.signed_op & bus.a[WIDTH-1], bus.a};
                    mcand_d = {bus.signed_op & bus.b[WIDTH-1], bus.b};
                    acc_d   = '0;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                acc_d = step_s[2*N:N];
                mq_d  = step_s[N-1:0];
                q1_d  = mq_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    // Last step: the low PW bits of {A,Q} are the exact product
                    product_d = step_s[PW-1:0];
                    state_d   = S_DONE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; rst returns everything to zero/IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mq_q      <= '0;
            mcand_q   <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            mcand_q   <= mcand_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.product   = product_q;
endmodule
